// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Purpose:
//   APB3 requester. It turns a single-beat command from the local bus into one
//   APB transfer (SETUP, then ACCESS until pready) and reports completion with a
//   one-cycle response strobe. A bounded wait in ACCESS aborts the transfer if
//   a slave never asserts pready.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  max ACCESS cycles without pready before abort (0 = never abort)
//
// Ports:
//   pclk, preset_n             clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_write/addr/wdata       command fields (sampled on accept only)
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata                  read data (0 for writes, errors, timeouts),
//                              held until the next completion
//   rsp_err, rsp_timeout       error / timeout flags, valid with rsp_valid
//   paddr/pwrite/pwdata        APB request fields
//   psel/penable               APB phase control
//   prdata/pready/pslverr      APB completion inputs
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // Wait counter: wide enough to hold TIMEOUT, never narrower than one bit.
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                timeout_hit;

    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_timeout_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                psel_q;
    logic                penable_q;

    // Saturating increment: a stuck slave with the timeout disabled must not
    // wrap the counter back to zero.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The abort fires on the edge that closes the TIMEOUT-th ACCESS cycle.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
        end else begin
            // Response flags are single-cycle pulses.
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        paddr_q     <= cmd_addr;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_wdata;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        // A ready slave wins over a timeout on the same edge.
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr;
                        rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (timeout_hit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign psel        = psel_q;
    assign penable     = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Directed bench for apb_master (ADDR_W=32, DATA_W=32, TIMEOUT=16).
// The bench plays the APB slave: it drives pready/pslverr/prdata on the
// falling edge and samples every DUT output on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 999;   // wait count that never releases pready

    logic              pclk;
    logic              preset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One directed transfer plus its hand-computed outcome.
    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;      // ACCESS cycles with pready=0 before pready=1
        logic        slverr;
        logic [31:0] rdata;       // prdata presented by the slave
        int          exp_access;  // ACCESS cycles the DUT should spend
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    // Issue one command and act as the slave until the response arrives.
    task automatic run_vec(input vec_t v);
        int  access;
        bit  done;
        @(negedge pclk);
        check({v.name, " cmd_ready before"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge pclk);
        // SETUP cycle
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;   // must not leak into paddr
        check({v.name, " setup psel"},    64'(psel),    64'd1);
        check({v.name, " setup penable"}, 64'(penable), 64'd0);
        check({v.name, " setup paddr"},   64'(paddr),   64'(v.addr));
        check({v.name, " setup pwrite"},  64'(pwrite),  64'(v.write));
        if (v.write) check({v.name, " setup pwdata"}, 64'(pwdata), 64'(v.wdata));
        access = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (!(psel && penable && paddr == v.addr && pwrite == v.write)) begin
                    check({v.name, " access phase {psel,penable,addr ok}"},
                          {62'd0, psel, penable}, 64'd3);
                end
                pready  = (access == v.wait_n);
                pslverr = v.slverr;
                prdata  = v.rdata;
                access++;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0BAD_0BAD;
        check({v.name, " completed"},     64'(done),        64'd1);
        check({v.name, " access cycles"}, 64'(access),      64'(v.exp_access));
        check({v.name, " rsp_err"},       64'(rsp_err),     64'(v.exp_err));
        check({v.name, " rsp_timeout"},   64'(rsp_timeout), 64'(v.exp_to));
        check({v.name, " rsp_rdata"},     64'(rsp_rdata),   64'(v.exp_rdata));
        check({v.name, " psel after"},    64'(psel),        64'd0);
        check({v.name, " cmd_ready after"}, 64'(cmd_ready), 64'd1);
        @(negedge pclk);
        check({v.name, " rsp_valid pulse"}, {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'd0);
        check({v.name, " rsp_rdata hold"},  64'(rsp_rdata), 64'(v.exp_rdata));
    endtask

    // Expected per-cycle trace for back-to-back: {psel, penable, rsp_valid}
    logic [2:0] b2b_exp[6];

    initial begin
        vecs[0] = '{"zw_write", 1'b1, 32'h10,  32'hDEAD_BEEF, 0,     1'b0, 32'h1111_1111, 1,  1'b0, 1'b0, 32'h0};
        vecs[1] = '{"rd_wait1", 1'b0, 32'h10,  32'h0,         1,     1'b0, 32'hCAFE_F00D, 2,  1'b0, 1'b0, 32'hCAFE_F00D};
        vecs[2] = '{"slv_err",  1'b0, 32'h100, 32'h0,         0,     1'b1, 32'h1234_5678, 1,  1'b1, 1'b0, 32'h0};
        vecs[3] = '{"timeout",  1'b0, 32'h20,  32'h0,         NEVER, 1'b0, 32'h5555_5555, 16, 1'b1, 1'b1, 32'h0};
        vecs[4] = '{"rdy_at_to",1'b0, 32'h24,  32'h0,         15,    1'b0, 32'h0000_55AA, 16, 1'b0, 1'b0, 32'h0000_55AA};
        vecs[5] = '{"wr_err_w3",1'b1, 32'h30,  32'h7777_0000, 3,     1'b1, 32'h9999_9999, 4,  1'b1, 1'b0, 32'h0};
        vecs[6] = '{"rd_wait2", 1'b0, 32'h40,  32'h0,         2,     1'b0, 32'h0BAD_F00D, 3,  1'b0, 1'b0, 32'h0BAD_F00D};

        b2b_exp[0] = 3'b110;  // first SETUP
        b2b_exp[1] = 3'b010 | 3'b100;  // first ACCESS: psel=1, penable=1
        b2b_exp[2] = 3'b001;  // IDLE gap, rsp_valid
        b2b_exp[3] = 3'b100;  // second SETUP
        b2b_exp[4] = 3'b110;  // second ACCESS
        b2b_exp[5] = 3'b001;  // second response
        b2b_exp[0] = 3'b100;  // SETUP is psel=1, penable=0

        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        preset_n  = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge pclk);
        check("reset psel",      64'(psel),      64'd0);
        check("reset penable",   64'(penable),   64'd0);
        check("reset cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset rsp",       {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'd0);
        check("reset paddr",     64'(paddr),     64'd0);
        check("reset pwdata",    64'(pwdata),    64'd0);
        check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        preset_n = 1'b1;
        #1;
        check("cmd_ready before first edge", 64'(cmd_ready), 64'd0);
        @(negedge pclk);
        check("cmd_ready after first edge",  64'(cmd_ready), 64'd1);

        // ---- table-driven transfers ----
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // ---- back-to-back with cmd_valid held high ----
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h4;
        cmd_wdata = 32'hA5A5_A5A5;
        pready    = 1'b1;
        prdata    = 32'h0000_0077;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            check($sformatf("b2b cycle %0d {psel,penable,rsp_valid}", k),
                  {61'd0, psel, penable, rsp_valid}, 64'(b2b_exp[k]));
            if (k == 0) begin
                check("b2b first pwdata", 64'(pwdata), 64'hA5A5_A5A5);
                check("b2b first pwrite", 64'(pwrite), 64'd1);
                cmd_write = 1'b0;   // second command: read 0x4
            end
            if (k == 3) begin
                check("b2b second pwrite", 64'(pwrite), 64'd0);
                check("b2b second paddr",  64'(paddr),  64'h4);
                cmd_valid = 1'b0;
            end
            if (k == 5) begin
                check("b2b read data", 64'(rsp_rdata), 64'h77);
                check("b2b read err",  64'(rsp_err),   64'd0);
            end
        end
        pready = 1'b0;

        // ---- reset in the middle of ACCESS ----
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h50;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        check("midrst in access", {62'd0, psel, penable}, 64'd3);
        #2;
        preset_n = 1'b0;
        #1;
        check("midrst psel async",    64'(psel),    64'd0);
        check("midrst penable async", 64'(penable), 64'd0);
        pready = 1'b1;   // late pready must not revive the lost transfer
        @(negedge pclk);
        preset_n = 1'b1;
        pready   = 1'b0;
        #1;
        check("midrst cmd_ready low", 64'(cmd_ready), 64'd0);
        begin
            int rsp_seen = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge pclk);
                if (rsp_valid) rsp_seen++;
                if (k == 0) check("midrst cmd_ready after edge", 64'(cmd_ready), 64'd1);
            end
            check("midrst no rsp_valid", 64'(rsp_seen), 64'd0);
        end

        // ---- recovery after reset ----
        run_vec(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
